cursor_select_ctrl: RTL and testbench
=====================================

// Module: cursor_select_ctrl
// PURPOSE
// Upstream feeder of the VGA board display. Debounces the five board buttons, moves the 0..63 cursor,
// runs the piece-selection FSM and drives CURSOR_ADDR/SELECT_ADDR/SELECT_EN to the display.
// Issues a from/to move request to game logic over a valid/ready handshake.
// Square address = row*8+col: row = addr[5:3] (row 0 at top of screen), col = addr[2:0].
// PARAMETERS
// DEBOUNCE_CYCLES  500000  consecutive equal synced samples before a button level is accepted (10 ms @ 50 MHz)
// DB_W             20      debounce counter width; must satisfy 2**DB_W > DEBOUNCE_CYCLES
// START_ADDR       6'd52   cursor position after reset
// PORTS
// CLK          in   1    system clock; single clock domain
// RESET_N      in   1    asynchronous, active-low reset
// BTN_UP/BTN_DOWN/BTN_LEFT/BTN_RIGHT/BTN_CENTER  in  1 each  raw async push buttons, active-high
// BOARD        in   256  board state: square k at [4k+3:4k]; bit3 = colour (0 white, 1 black),
//                        [2:0] = type, 3'b000 = empty
// TURN         in   1    side to move (0 white, 1 black)
// MOVE_READY   in   1    game logic accepts the move request
// CURSOR_ADDR  out  6    cursor square
// SELECT_ADDR  out  6    selected square; valid only while SELECT_EN = 1
// SELECT_EN    out  1    a piece is selected
// MOVE_VALID   out  1    move request pending
// MOVE_FROM    out  6    source square; stable while MOVE_VALID = 1
// MOVE_TO      out  6    destination square; stable while MOVE_VALID = 1
// BEHAVIOUR
// Reset values: CURSOR_ADDR = START_ADDR; SELECT_ADDR = 0; SELECT_EN = 0; MOVE_VALID = 0;
//   MOVE_FROM = MOVE_TO = 0; state = IDLE; all debounced levels = 0; all counters = 0.
// Input conditioning, per button:
// - 2-FF synchroniser, then counter.
// - Counter clears when synced level == debounced level; otherwise increments.
// - When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
// - A 0->1 debounced transition makes a 1-cycle press pulse.
// - Raw press to pulse latency = 2 + DEBOUNCE_CYCLES cycles. Held buttons never repeat.
// Cursor movement:
// - Applied in the cycle after a pulse. UP row-1, DOWN row+1, LEFT col-1, RIGHT col+1.
// - Edge behaviour is set by the CURSOR_WRAP_EN macro (see CONFIGURATION).
// - Simultaneous direction pulses: priority UP > DOWN > LEFT > RIGHT; the lower-priority pulses are dropped.
// - Direction pulses are ignored in REQ.
// FSM (states IDLE, SELECTED, REQ). Let P = BOARD piece at the current CURSOR_ADDR;
// "own" means P.type != 0 and P.colour == TURN.
// - IDLE: CENTER with own P -> SELECTED; SELECT_ADDR <= CURSOR_ADDR, SELECT_EN <= 1.
//   CENTER on an empty or enemy square -> no change.
// - SELECTED:
//   - CENTER on SELECT_ADDR -> IDLE, SELECT_EN <= 0 (deselect).
//   - CENTER on another own square -> stay in SELECTED; SELECT_ADDR <= CURSOR_ADDR (reselect).
//   - CENTER on any other square -> REQ; MOVE_FROM <= SELECT_ADDR, MOVE_TO <= CURSOR_ADDR,
//     MOVE_VALID <= 1; SELECT_EN stays 1.
// - REQ: the transfer occurs on the first CLK edge with MOVE_VALID & MOVE_READY.
//   That same edge gives MOVE_VALID <= 0, SELECT_EN <= 0, state <= IDLE.
//   CENTER pulses are ignored in REQ. MOVE_FROM/MOVE_TO hold their values after the transfer.
// - CENTER and a direction pulse in the same cycle: CENTER uses the pre-move CURSOR_ADDR;
//   the move is also applied.
// - MOVE_READY high outside REQ has no effect. RESET_N low in any state (including mid-REQ)
//   immediately forces the reset values.
// - All outputs are registered. CENTER pulse -> SELECT_EN/MOVE_VALID change: 1 cycle.
// CONFIGURATION
// CURSOR_WRAP_EN defined: the cursor wraps within its row or column (col 7 + RIGHT -> col 0;
//   row 0 + UP -> row 7). Only the 3-bit row or column field changes.
// Not defined: the cursor clamps at the board edges (a move past an edge leaves CURSOR_ADDR unchanged).
// TESTING (bench: DEBOUNCE_CYCLES=4, START_ADDR=52, initial chess position, TURN=0)
// 1. Reset; pulse LEFT -> CURSOR_ADDR 51. A 2-cycle raw glitch on BTN_LEFT -> no change.
// 2. CENTER at 52 (white pawn) -> SELECT_EN=1, SELECT_ADDR=52. UP twice, CENTER
//    -> MOVE_VALID=1, FROM=52, TO=36. Hold MOVE_READY=0 for 5 cycles: outputs stable.
//    Raise MOVE_READY -> MOVE_VALID=0 and SELECT_EN=0 next edge.
// 3. Cursor to 12 (black pawn), CENTER -> SELECT_EN stays 0. Select 52, CENTER at 52 again -> SELECT_EN=0.
// 4. Select 52, move to 51, CENTER -> SELECT_ADDR=51, no MOVE_VALID.
// 5. Cursor at 7, RIGHT -> 0 with CURSOR_WRAP_EN, 7 without. Cursor at 3, UP -> 59 / 3.
// 6. UP and LEFT pulses in the same cycle from 52 -> 44. RESET_N low during REQ
//    -> MOVE_VALID=0 and CURSOR_ADDR=52 asynchronously.

Source files
------------

// File: rtl/cursor_select_ctrl.sv
// Board cursor and piece-selection controller feeding the VGA display and the game-logic move handshake.
// Build option: define CURSOR_WRAP_EN to wrap the cursor within its row/column instead of clamping at the edges.
module cursor_select_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          DB_W            = 20,
  parameter logic [5:0]  START_ADDR      = 6'd52
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         BTN_UP,
  input  logic         BTN_DOWN,
  input  logic         BTN_LEFT,
  input  logic         BTN_RIGHT,
  input  logic         BTN_CENTER,
  input  logic [255:0] BOARD,
  input  logic         TURN,
  input  logic         MOVE_READY,
  output logic [5:0]   CURSOR_ADDR,
  output logic [5:0]   SELECT_ADDR,
  output logic         SELECT_EN,
  output logic         MOVE_VALID,
  output logic [5:0]   MOVE_FROM,
  output logic [5:0]   MOVE_TO
);

  // state    | meaning
  // IDLE     | nothing selected
  // SELECTED | SELECT_ADDR holds a piece of the side to move
  // REQ      | move request offered to game logic, waiting for MOVE_READY
  typedef enum logic [1:0] {IDLE, SELECTED, REQ} state_t;

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_CENTER = 4;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  state_t          state;
  logic [4:0]      btn_raw;
  logic [4:0]      sync1;
  logic [4:0]      sync2;
  logic [4:0]      db_lvl;
  logic [4:0]      press;
  logic [DB_W-1:0] db_cnt [5];

  assign btn_raw = {BTN_CENTER, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // The press pulse is issued on the same edge the debounced level rises.
  for (genvar i = 0; i < 5; i++) begin : g_db
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        db_cnt[i] <= '0;
        db_lvl[i] <= 1'b0;
        press[i]  <= 1'b0;
      end else begin
        press[i] <= 1'b0;
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= sync2[i];
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [2:0] row_n;
  logic [2:0] col_n;
  logic [5:0] cursor_nxt;

  always_comb begin
    row_n = CURSOR_ADDR[5:3];
    col_n = CURSOR_ADDR[2:0];
`ifdef CURSOR_WRAP_EN
    if (press[B_UP])         row_n = row_n - 3'd1;
    else if (press[B_DOWN])  row_n = row_n + 3'd1;
    else if (press[B_LEFT])  col_n = col_n - 3'd1;
    else if (press[B_RIGHT]) col_n = col_n + 3'd1;
`else
    if (press[B_UP])         begin if (row_n != 3'd0) row_n = row_n - 3'd1; end
    else if (press[B_DOWN])  begin if (row_n != 3'd7) row_n = row_n + 3'd1; end
    else if (press[B_LEFT])  begin if (col_n != 3'd0) col_n = col_n - 3'd1; end
    else if (press[B_RIGHT]) begin if (col_n != 3'd7) col_n = col_n + 3'd1; end
`endif
    cursor_nxt = {row_n, col_n};
  end

  logic [3:0] piece;
  logic       own;

  assign piece = BOARD[{CURSOR_ADDR, 2'b00} +: 4];
  assign own   = (piece[2:0] != 3'b000) && (piece[3] == TURN);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      CURSOR_ADDR <= START_ADDR;
      SELECT_ADDR <= '0;
      SELECT_EN   <= 1'b0;
      MOVE_VALID  <= 1'b0;
      MOVE_FROM   <= '0;
      MOVE_TO     <= '0;
    end else begin
      if (state != REQ) CURSOR_ADDR <= cursor_nxt;
      case (state)
        IDLE: begin
          if (press[B_CENTER] && own) begin
            state       <= SELECTED;
            SELECT_ADDR <= CURSOR_ADDR;
            SELECT_EN   <= 1'b1;
          end
        end
        SELECTED: begin
          if (press[B_CENTER]) begin
            if (CURSOR_ADDR == SELECT_ADDR) begin
              state     <= IDLE;
              SELECT_EN <= 1'b0;
            end else if (own) begin
              SELECT_ADDR <= CURSOR_ADDR;
            end else begin
              state      <= REQ;
              MOVE_FROM  <= SELECT_ADDR;
              MOVE_TO    <= CURSOR_ADDR;
              MOVE_VALID <= 1'b1;
            end
          end
        end
        REQ: begin
          if (MOVE_VALID && MOVE_READY) begin
            state      <= IDLE;
            MOVE_VALID <= 1'b0;
            SELECT_EN  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Randomized self-checking bench for cursor_select_ctrl against a square/selection level reference model.
// Expected edge behaviour follows CURSOR_WRAP_EN when defined.
module tb_cursor_select_ctrl;

  localparam int N = 4;
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [4:0] M_UP = 5'b00001, M_DOWN = 5'b00010, M_LEFT = 5'b00100,
                         M_RIGHT = 5'b01000, M_CENTER = 5'b10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   btns = '0;
  logic [255:0] board;
  logic         turn = 1'b0;
  logic         move_ready = 1'b0;
  logic [5:0]   cursor_addr, select_addr, move_from, move_to;
  logic         select_en, move_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  int m_cur, m_sa, m_from, m_to;
  bit m_sel, m_mv;

  cursor_select_ctrl #(.DEBOUNCE_CYCLES(N), .DB_W(3), .START_ADDR(6'd52)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .BTN_UP(btns[0]), .BTN_DOWN(btns[1]), .BTN_LEFT(btns[2]),
    .BTN_RIGHT(btns[3]), .BTN_CENTER(btns[4]),
    .BOARD(board), .TURN(turn), .MOVE_READY(move_ready),
    .CURSOR_ADDR(cursor_addr), .SELECT_ADDR(select_addr), .SELECT_EN(select_en),
    .MOVE_VALID(move_valid), .MOVE_FROM(move_from), .MOVE_TO(move_to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic bit own(int a);
    logic [3:0] p;
    p = board[a*4 +: 4];
    return (p[2:0] != 3'b000) && (p[3] == turn);
  endfunction

  function automatic int step(int a, int d);
    int r, c;
    r = a / 8;
    c = a % 8;
    case (d)
      0: r = WRAP ? (r + 7) % 8 : (r > 0 ? r - 1 : r);
      1: r = WRAP ? (r + 1) % 8 : (r < 7 ? r + 1 : r);
      2: c = WRAP ? (c + 7) % 8 : (c > 0 ? c - 1 : c);
      default: c = WRAP ? (c + 1) % 8 : (c < 7 ? c + 1 : c);
    endcase
    return r * 8 + c;
  endfunction

  task automatic model_reset();
    m_cur = 52; m_sa = 0; m_sel = 0; m_mv = 0; m_from = 0; m_to = 0;
  endtask

  task automatic model_press(input logic [4:0] m);
    int pre;
    pre = m_cur;
    if (!m_mv) begin
      if (m[4]) begin
        if (!m_sel) begin
          if (own(pre)) begin m_sel = 1; m_sa = pre; end
        end else if (pre == m_sa) m_sel = 0;
        else if (own(pre)) m_sa = pre;
        else begin m_mv = 1; m_from = m_sa; m_to = pre; end
      end
      if (m[0])      m_cur = step(pre, 0);
      else if (m[1]) m_cur = step(pre, 1);
      else if (m[2]) m_cur = step(pre, 2);
      else if (m[3]) m_cur = step(pre, 3);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cursor"}, cursor_addr, m_cur);
    chk({tag, ".sel_en"}, select_en, m_sel);
    if (m_sel) chk({tag, ".sel_addr"}, select_addr, m_sa);
    chk({tag, ".move_valid"}, move_valid, m_mv);
    chk({tag, ".move_from"}, move_from, m_from);
    chk({tag, ".move_to"}, move_to, m_to);
  endtask

  task automatic press(input logic [4:0] m, input string tag);
    @(negedge clk) btns = m;
    repeat (8) @(negedge clk);
    btns = '0;
    repeat (8) @(negedge clk);
    model_press(m);
    check_all(tag);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk) move_ready = 1'b1;
    @(negedge clk) move_ready = 1'b0;
    if (m_mv) begin m_mv = 0; m_sel = 0; end
    check_all(tag);
  endtask

  task automatic goto_sq(input int a);
    int r, c, guard;
    guard = 0;
    while (m_cur != a && guard < 20) begin
      r = m_cur / 8; c = m_cur % 8;
      if (r > a / 8)      press(M_UP, "goto");
      else if (r < a / 8) press(M_DOWN, "goto");
      else if (c > a % 8) press(M_LEFT, "goto");
      else                press(M_RIGHT, "goto");
      guard++;
    end
    chk("goto_reached", m_cur, a);
  endtask

  task automatic init_board();
    int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    board = '0;
    for (int c = 0; c < 8; c++) begin
      board[(0 * 8 + c) * 4 +: 4] = {1'b1, 3'(back[c])};
      board[(1 * 8 + c) * 4 +: 4] = {1'b1, 3'd1};
      board[(6 * 8 + c) * 4 +: 4] = {1'b0, 3'd1};
      board[(7 * 8 + c) * 4 +: 4] = {1'b0, 3'(back[c])};
    end
  endtask

  initial begin
    logic [4:0] m;
    init_board();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");
    chk("reset.sel_addr", select_addr, 0);

    // exact press latency: pulse after 2+N edges, cursor one edge later
    @(negedge clk) btns = M_LEFT;
    repeat (N + 2) @(negedge clk);
    chk("latency.before", cursor_addr, 52);
    @(negedge clk);
    chk("latency.after", cursor_addr, 51);
    @(negedge clk) btns = '0;
    repeat (8) @(negedge clk);
    model_press(M_LEFT);
    check_all("left");

    @(negedge clk) btns = M_LEFT;
    repeat (2) @(negedge clk);
    btns = '0;
    repeat (10) @(negedge clk);
    chk("glitch", cursor_addr, 51);
    press(M_RIGHT, "back52");

    press(M_CENTER, "sel52");
    chk("sel52.en", select_en, 1);
    press(M_UP, "up1");
    press(M_UP, "up2");
    press(M_CENTER, "req");
    chk("req.from", move_from, 52);
    chk("req.to", move_to, 36);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("req.hold_valid", move_valid, 1);
      chk("req.hold_sel", select_en, 1);
      chk("req.hold_from", move_from, 52);
      chk("req.hold_to", move_to, 36);
    end
    press(M_UP, "req_ignore_up");
    press(M_CENTER, "req_ignore_center");
    @(negedge clk) move_ready = 1'b1;
    @(negedge clk) move_ready = 1'b0;
    chk("xfer.valid", move_valid, 0);
    chk("xfer.sel", select_en, 0);
    m_mv = 0; m_sel = 0;
    check_all("xfer");

    goto_sq(12);
    press(M_CENTER, "enemy");
    chk("enemy.sel", select_en, 0);
    goto_sq(52);
    press(M_CENTER, "sel52b");
    press(M_CENTER, "desel52");
    chk("desel.sel", select_en, 0);

    press(M_CENTER, "sel52c");
    press(M_LEFT, "to51");
    press(M_CENTER, "resel51");
    chk("resel.addr", select_addr, 51);
    chk("resel.valid", move_valid, 0);
    press(M_CENTER, "desel51");

    goto_sq(7);
    press(M_RIGHT, "edge_right");
    chk("edge_right.const", cursor_addr, WRAP ? 0 : 7);
    goto_sq(3);
    press(M_UP, "edge_up");
    chk("edge_up.const", cursor_addr, WRAP ? 59 : 3);

    goto_sq(52);
    press(M_UP | M_LEFT, "up_left");
    chk("up_left.const", cursor_addr, 44);

    press(M_RIGHT, "to45");
    press(M_DOWN, "to53");
    press(M_CENTER, "sel53");
    press(M_UP, "to45b");
    press(M_CENTER, "req2");
    chk("req2.valid", move_valid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.valid", move_valid, 0);
    chk("async_rst.cursor", cursor_addr, 52);
    chk("async_rst.sel", select_en, 0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("after_rst");

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1:    handshake("rnd_hs");
        2:       begin
                   m = 5'($urandom_range(1, 31));
                   press(m, "rnd_combo");
                 end
        3:       begin
                   turn = ~turn;
                   press(M_CENTER, "rnd_turn_center");
                 end
        4, 5:    press(M_CENTER, "rnd_center");
        default: begin
                   m = 5'(1 << $urandom_range(0, 3));
                   press(m, "rnd_dir");
                 end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
